// File: rtl/qam_nco_quad.sv
// qam_nco_quad: phase-accumulator NCO with a folded quarter-wave table producing quadrature carriers
module qam_nco_quad #(
  parameter int PHASE_W = 16,
  parameter int LUT_W = 8,
  parameter int DATA_W = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [PHASE_W-1:0] phase_offset,
  output logic [DATA_W-1:0]  sin_out,
  output logic [DATA_W-1:0]  cos_out,
  output logic               out_valid
);
  localparam int N = 2 ** LUT_W;
  localparam longint A = longint'(2 ** (DATA_W - 1) - 1);
  localparam longint HALF_PI_Q30 = 64'sd1686629713;
  if (PHASE_W < LUT_W + 2) begin : g_bad_params
    $error("PHASE_W must be at least LUT_W+2");
  end
  function automatic logic [DATA_W-1:0] quarter_sine(input int k);
    longint x, t, s;
    x = HALF_PI_Q30 * longint'(k) / longint'(N);
    t = x;
    s = x;
    for (int n = 1; n < 10; n++) begin
      t = -((((t * x) >>> 30) * x) >>> 30) / longint'(4 * n * n + 2 * n);
      s = s + t;
    end
    s = (A * s + (longint'(1) <<< 29)) >>> 30;
    return s[DATA_W-1:0];
  endfunction
  logic [DATA_W-1:0] q_tab [N+1];
  for (genvar k = 0; k <= N; k++) begin : g_tab
    assign q_tab[k] = quarter_sine(k);
  end
  logic [PHASE_W-1:0] acc, base, ph0;
  logic [1:0] quad;
  logic [LUT_W-1:0] a;
  logic [LUT_W:0] idx_s, idx_c;
  logic [DATA_W-1:0] mag_s, mag_c;
  logic neg_s, neg_c, v0, v1;
  logic unused_ph;
  assign base = sync_clr ? '0 : acc;
  assign quad = ph0[PHASE_W-1 -: 2];
  assign a = ph0[PHASE_W-3 -: LUT_W];
  assign idx_s = quad[0] ? (LUT_W+1)'(N) - {1'b0, a} : {1'b0, a};
  assign idx_c = quad[0] ? {1'b0, a} : (LUT_W+1)'(N) - {1'b0, a};
  assign unused_ph = ^ph0;
  // stage 0: advance the accumulator and latch the offset phase of the launched sample
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      acc <= '0;
      ph0 <= '0;
      v0 <= 1'b0;
    end else begin
      acc <= base + (en ? phase_inc : '0);
      if (en) ph0 <= base + phase_offset;
      v0 <= en;
    end
  // stage 1: quarter-wave lookups for sine and for the quadrant-advanced cosine
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      mag_s <= '0;
      mag_c <= '0;
      neg_s <= 1'b0;
      neg_c <= 1'b0;
      v1 <= 1'b0;
    end else begin
      mag_s <= q_tab[idx_s];
      mag_c <= q_tab[idx_c];
      neg_s <= quad[1];
      neg_c <= quad[1] ^ quad[0];
      v1 <= v0;
    end
  // stage 2: apply signs and hold outputs across bubbles
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      sin_out <= '0;
      cos_out <= '0;
      out_valid <= 1'b0;
    end else begin
      if (v1) begin
        sin_out <= neg_s ? -mag_s : mag_s;
        cos_out <= neg_c ? -mag_c : mag_c;
      end
      out_valid <= v1;
    end
endmodule

// File: tb/tb_qam_nco_quad.sv
// tb_qam_nco_quad: directed vector table plus multi-cycle sequences for the quadrature NCO
module tb_qam_nco_quad;
  localparam int PW = 16;
  localparam int LW = 8;
  localparam int DW = 8;
  localparam int A = 127;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic en = 1'b0;
  logic sync_clr = 1'b0;
  logic [PW-1:0] phase_inc = '0;
  logic [PW-1:0] phase_offset = '0;
  logic signed [DW-1:0] sin_out, cos_out;
  logic out_valid;
  int n_tests = 0;
  int n_fail = 0;
  int cap_s[$], cap_c[$], save_s[$];

  qam_nco_quad #(.PHASE_W(PW), .LUT_W(LW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .en(en), .sync_clr(sync_clr),
    .phase_inc(phase_inc), .phase_offset(phase_offset),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int rst, en, clr, inc, off, vld, s, c;
  } vec_t;
  vec_t vt [19];

  function automatic vec_t row(int r, int e, int cl, int i, int o, int v, int s, int c);
    vec_t x;
    x = '{r, e, cl, i, o, v, s, c};
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int n, input int inc, input int off, input int clr_at);
    cap_s.delete();
    cap_c.delete();
    Rst = 1'b1;
    #1;
    Rst = 1'b0;
    phase_inc = inc[PW-1:0];
    phase_offset = off[PW-1:0];
    for (int i = 0; i < n + 3; i++) begin
      en = (i < n);
      sync_clr = (i == clr_at);
      @(posedge Clk);
      @(negedge Clk);
      if (out_valid) begin
        cap_s.push_back(int'(sin_out));
        cap_c.push_back(int'(cos_out));
      end
    end
    en = 1'b0;
    sync_clr = 1'b0;
    check("capture_count", cap_s.size(), n);
  endtask

  initial begin
    int viol;
    vt[0]  = row(1, 0, 0, 0,     0, 0,    0,    0);
    vt[1]  = row(0, 1, 0, 16384, 0, 0,    0,    0);
    vt[2]  = row(0, 1, 0, 16384, 0, 0,    0,    0);
    vt[3]  = row(0, 1, 0, 16384, 0, 1,    0,  127);
    vt[4]  = row(0, 1, 0, 16384, 0, 1,  127,    0);
    vt[5]  = row(0, 1, 0, 16384, 0, 1,    0, -127);
    vt[6]  = row(0, 1, 0, 16384, 0, 1, -127,    0);
    vt[7]  = row(0, 1, 0, 16384, 0, 1,    0,  127);
    vt[8]  = row(1, 0, 0, 16384, 0, 0,    0,    0);
    vt[9]  = row(0, 1, 0, 16384, 0, 0,    0,    0);
    vt[10] = row(0, 0, 0, 16384, 0, 0,    0,    0);
    vt[11] = row(0, 1, 0, 16384, 0, 1,    0,  127);
    vt[12] = row(0, 0, 0, 16384, 0, 0,    0,  127);
    vt[13] = row(0, 1, 0, 16384, 0, 1,  127,    0);
    vt[14] = row(0, 0, 0, 16384, 0, 0,  127,    0);
    vt[15] = row(0, 1, 0, 16384, 0, 1,    0, -127);
    vt[16] = row(0, 0, 0, 16384, 0, 0,    0, -127);
    vt[17] = row(0, 0, 0, 16384, 0, 1, -127,    0);
    vt[18] = row(0, 0, 0, 16384, 0, 0, -127,    0);
    @(negedge Clk);
    for (int i = 0; i < 19; i++) begin
      Rst = vt[i].rst[0];
      en = vt[i].en[0];
      sync_clr = vt[i].clr[0];
      phase_inc = vt[i].inc[PW-1:0];
      phase_offset = vt[i].off[PW-1:0];
      if (vt[i].rst != 0) begin
        #1;
        check($sformatf("vec%0d_rst_valid", i), int'(out_valid), 0);
        check($sformatf("vec%0d_rst_sin", i), int'(sin_out), 0);
        check($sformatf("vec%0d_rst_cos", i), int'(cos_out), 0);
      end
      @(posedge Clk);
      @(negedge Clk);
      check($sformatf("vec%0d_valid", i), int'(out_valid), vt[i].vld);
      check($sformatf("vec%0d_sin", i), int'(sin_out), vt[i].s);
      check($sformatf("vec%0d_cos", i), int'(cos_out), vt[i].c);
    end
    // one table step per sample across a full cycle
    run(1024, 64, 0, -1);
    if (cap_s.size() == 1024) begin
      check("step_sin64", cap_s[64], 49);
      check("step_sin128", cap_s[128], 90);
      check("step_sin192", cap_s[192], 117);
      check("step_sin256", cap_s[256], 127);
      check("step_cos0", cap_c[0], 127);
      viol = 0;
      for (int k = 0; k < 256; k++) if (cap_s[k+1] < cap_s[k]) viol++;
      check("step_monotonic_viol", viol, 0);
      viol = 0;
      for (int k = 0; k < 512; k++) if (cap_s[k] != -cap_s[k+512]) viol++;
      check("step_halfwave_viol", viol, 0);
      viol = 0;
      for (int k = 0; k < 1024; k++) begin
        int p;
        p = cap_s[k] * cap_s[k] + cap_c[k] * cap_c[k];
        if (p > A * A + 2 * A || p < A * A - 2 * A) viol++;
      end
      check("step_power_viol", viol, 0);
      viol = 0;
      for (int k = 0; k < 1024; k++) if (cap_s[k] == -128 || cap_c[k] == -128) viol++;
      check("step_neg_full_scale", viol, 0);
    end
    // quarter-cycle offset turns sine into cosine
    run(20, 4096, 16384, -1);
    save_s = cap_s;
    run(20, 4096, 0, -1);
    if (cap_c.size() == 20 && save_s.size() == 20) begin
      check("ofs0_sin1", cap_s[1], 49);
      check("ofs0_cos1", cap_c[1], 117);
      viol = 0;
      for (int k = 0; k < 20; k++) if (save_s[k] != cap_c[k]) viol++;
      check("offset_vs_cos_viol", viol, 0);
    end
    // sync_clr together with the sixth launch
    run(10, 4096, 0, 5);
    if (cap_s.size() == 10) begin
      check("clr_pre_sin", cap_s[4], 127);
      check("clr_pre_cos", cap_c[4], 0);
      check("clr_sin", cap_s[5], 0);
      check("clr_cos", cap_c[5], 127);
      check("clr_next_sin", cap_s[6], 49);
      check("clr_next_cos", cap_c[6], 117);
    end
    // maximum increment wraps backwards through phase zero
    run(4, 65535, 0, -1);
    if (cap_s.size() == 4) begin
      check("wrap_sin0", cap_s[0], 0);
      check("wrap_sin1", cap_s[1], -1);
      check("wrap_cos1", cap_c[1], 127);
      check("wrap_sin3", cap_s[3], -1);
    end
    // zero increment gives a constant sample at the offset phase
    run(4, 0, 16384, -1);
    if (cap_s.size() == 4) begin
      check("const_sin3", cap_s[3], 127);
      check("const_cos3", cap_c[3], 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
